br_pc_unit: RTL
===============

// Module: br_pc_unit
// PURPOSE
//  PC register and branch-resolution stage, directly downstream of the branch comparator.
//  Consumes br_less/br_equal, decodes branch type, selects the comparator's signed/unsigned mode, produces next PC.
//  Redirects to the target for taken branches and jumps; traps misaligned targets.
//  Holds in TRAP until software acknowledges.
// PARAMETERS
//  PC_W      16        PC width in bits
//  PC_INC    4         sequential PC increment (bytes)
//  RESET_PC  16'h0000  PC value after reset
//  TRAP_VEC  16'h00F0  PC loaded on misaligned-target trap
// PORTS
//  clk_i          in   1     clock
//  rst_ni         in   1     asynchronous reset, active-low
//  stall_i        in   1     hold PC this cycle (RUN state only)
//  is_branch_i    in   1     current instruction is conditional branch
//  is_jump_i      in   1     current instruction is unconditional jump
//  br_type_i      in   3     funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
//  target_i       in   PC_W  branch/jump target address
//  br_less_i      in   1     from comparator
//  br_equal_i     in   1     from comparator; valid only while br_unsigned_o=0
//  br_unsigned_o  out  1     comparator mode select
//  trap_ack_i     in   1     software acknowledge, leaves TRAP
//  pc_o           out  PC_W  current PC (registered)
//  pc_plus_o      out  PC_W  pc_o + PC_INC (link value)
//  taken_o        out  1     redirect this cycle (combinational)
//  trap_o         out  1     high while in TRAP
//  epc_o          out  PC_W  PC of faulting instruction (registered)
// BEHAVIOUR
//  Reset: pc_o=RESET_PC, state RUN, trap_o=0, epc_o=0, counters 0; async assert, applies mid-operation.
//  br_unsigned_o = br_type_i[2] & br_type_i[1]; 0 for BEQ/BNE so br_equal_i is valid.
//  Condition: BEQ eq; BNE !eq; BLT/BLTU less; BGE/BGEU !less; codes 010/011 never taken.
//  taken_o = state==RUN & !stall_i & (is_jump_i | is_branch_i & cond); jump wins if both asserted.
//  pc_plus_o = pc_o + PC_INC mod 2^PC_W; 0xFFFC wraps to 0x0000.
//  FSM RUN:
//   stall_i=1 -> pc holds.
//   taken & target_i[1:0]!=0 -> pc<=TRAP_VEC, epc<=pc_o, go TRAP.
//   taken & aligned -> pc<=target_i.
//   else pc<=pc_plus_o.
//  FSM TRAP: pc holds TRAP_VEC, taken_o=0, stall_i ignored.
//   trap_ack_i=1 -> RUN; sequential fetch from TRAP_VEC resumes next cycle.
//  Latency: redirect visible on pc_o one cycle after taken_o.
// CONFIGURATION
//  BR_PC_STATS_EN defined: adds outputs br_cnt_o[15:0] and taken_cnt_o[15:0].
//   br_cnt_o counts branches evaluated in RUN with !stall_i; taken_cnt_o counts taken ones.
//   Counters saturate at 16'hFFFF and clear on reset.
//  BR_PC_STATS_EN undefined: ports and logic absent.
// STRUCTURE
//  Package br_pkg: br_type_e enum (6 codes), br_state_e {RUN, TRAP}, PC_INC/TRAP_VEC defaults.
//  Sub-module br_cond: combinational funct3 decode -> cond, br_unsigned.
//  Top holds FSM, PC and EPC registers, stats counters.
// TESTING
//  Reset mid-run: pc_o=0x0040, drop rst_ni -> pc_o=0x0000 without clock edge, trap_o=0.
//  BEQ: pc=0x0010, type 000, eq=1, target 0x0100 -> taken_o=1, pc_o=0x0100 next; eq=0 -> 0x0014.
//  BLTU: type 110 -> br_unsigned_o=1; less=1 -> taken; BGEU, less=1 -> pc_o=pc+4.
//  Misaligned jump: pc=0x0020, target 0x0102 -> pc_o=0x00F0, epc_o=0x0020, trap_o=1.
//   Holds 5 cycles; trap_ack_i -> RUN, then 0x00F4.
//  Wrap and stall: pc=0xFFFC sequential -> 0x0000; stall_i=1 with jump -> taken_o=0, pc held.
//  BR_PC_STATS_EN: 3 branches, 2 taken, 1 stalled branch -> br_cnt_o=3, taken_cnt_o=2.

Source files
------------

// File: rtl/br_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg
// Shared types and defaults for the branch-resolution / PC stage.
//   br_type_e   : funct3 encodings of the conditional branches
//   br_state_e  : PC stage state (RUN, TRAP)
//   DEF_PC_INC  : default sequential PC increment in bytes
//   DEF_TRAP_VEC: default PC loaded on a misaligned-target trap
// ---------------------------------------------------------------------------
package br_pkg;

   typedef enum logic [2:0] {
      BR_EQ  = 3'b000,
      BR_NE  = 3'b001,
      BR_LT  = 3'b100,
      BR_GE  = 3'b101,
      BR_LTU = 3'b110,
      BR_GEU = 3'b111
   } br_type_e;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } br_state_e;

   localparam int          DEF_PC_INC   = 4;
   localparam logic [15:0] DEF_TRAP_VEC = 16'h00F0;

endpackage : br_pkg

// File: rtl/br_pc_unit_cond.sv
// ---------------------------------------------------------------------------
// br_cond
// Combinational funct3 decode for conditional branches.
// Ports:
//   br_type_i     in  3  funct3 of the branch
//   br_less_i     in  1  comparator "less than" result
//   br_equal_i    in  1  comparator "equal" result (valid in signed mode only)
//   cond_o        out 1  branch condition holds
//   br_unsigned_o out 1  comparator mode select (1 = unsigned compare)
// ---------------------------------------------------------------------------
module br_cond
   import br_pkg::*;
(
   input  logic [2:0] br_type_i,
   input  logic       br_less_i,
   input  logic       br_equal_i,
   output logic       cond_o,
   output logic       br_unsigned_o
);

   // Only BLTU/BGEU need an unsigned compare. BEQ/BNE keep the comparator
   // in signed mode because that is the only mode where br_equal_i is valid.
   assign br_unsigned_o = br_type_i[2] & br_type_i[1];

   always_comb begin
      cond_o = 1'b0;
      case (br_type_e'(br_type_i))
         BR_EQ:         cond_o = br_equal_i;
         BR_NE:         cond_o = ~br_equal_i;
         BR_LT, BR_LTU: cond_o = br_less_i;
         BR_GE, BR_GEU: cond_o = ~br_less_i;
         default:       cond_o = 1'b0;   // 010 / 011 are never taken
      endcase
   end

endmodule : br_cond

// File: rtl/br_pc_unit.sv
// ---------------------------------------------------------------------------
// br_pc_unit
// PC register and branch-resolution stage sitting right after the branch
// comparator. Decodes the branch type, selects the comparator mode, decides
// whether to redirect, and produces the next PC. Misaligned redirect targets
// send the stage to TRAP, where it holds until software acknowledges.
//
// Optional feature macro: BR_PC_STATS_EN
//   When defined, adds saturating 16-bit counters br_cnt_o (branches
//   evaluated in RUN without stall) and taken_cnt_o (those that redirected).
//
// Ports:
//   clk_i          in   1     clock
//   rst_ni         in   1     asynchronous reset, active-low
//   stall_i        in   1     hold PC this cycle (RUN only)
//   is_branch_i    in   1     current instruction is a conditional branch
//   is_jump_i      in   1     current instruction is an unconditional jump
//   br_type_i      in   3     branch funct3
//   target_i       in   PC_W  branch/jump target
//   br_less_i      in   1     comparator less-than
//   br_equal_i     in   1     comparator equal
//   br_unsigned_o  out  1     comparator mode select
//   trap_ack_i     in   1     software acknowledge, leaves TRAP
//   pc_o           out  PC_W  current PC (registered)
//   pc_plus_o      out  PC_W  pc_o + PC_INC (link value)
//   taken_o        out  1     redirect this cycle (combinational)
//   trap_o         out  1     high while in TRAP (registered)
//   epc_o          out  PC_W  PC of the faulting instruction (registered)
//   state_o        out  1     current FSM state (debug visibility)
//   br_cnt_o       out  16    [BR_PC_STATS_EN] evaluated-branch count
//   taken_cnt_o    out  16    [BR_PC_STATS_EN] taken-branch count
//
// Timing: taken_o is combinational in the cycle the instruction is
// presented; the redirect appears on pc_o after the next rising clock.
// There is no valid/ready handshake here: a cycle with stall_i=0 in RUN
// consumes the presented instruction, stall_i=1 means "not consumed".
// ---------------------------------------------------------------------------
module br_pc_unit
   import br_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter int              PC_INC   = DEF_PC_INC,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(DEF_TRAP_VEC)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            stall_i,
   input  logic            is_branch_i,
   input  logic            is_jump_i,
   input  logic [2:0]      br_type_i,
   input  logic [PC_W-1:0] target_i,
   input  logic            br_less_i,
   input  logic            br_equal_i,
   output logic            br_unsigned_o,
   input  logic            trap_ack_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc_plus_o,
   output logic            taken_o,
   output logic            trap_o,
   output logic [PC_W-1:0] epc_o,
   output logic            state_o
`ifdef BR_PC_STATS_EN
   ,
   output logic [15:0]     br_cnt_o,
   output logic [15:0]     taken_cnt_o
`endif
);

   br_state_e       state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] epc_q;
   logic            trap_q;
   logic            cond;
   logic            active;
   logic            misaligned;

   br_cond u_cond (
      .br_type_i     (br_type_i),
      .br_less_i     (br_less_i),
      .br_equal_i    (br_equal_i),
      .cond_o        (cond),
      .br_unsigned_o (br_unsigned_o)
   );

   // The stage only consumes an instruction in RUN with no stall.
   assign active     = (state_q == RUN) & ~stall_i;
   // A jump redirects regardless of the branch condition.
   assign taken_o    = active & (is_jump_i | (is_branch_i & cond));
   assign misaligned = (target_i[1:0] != 2'b00);

   // Natural wrap at 2^PC_W is intended (0xFFFC + 4 -> 0x0000).
   assign pc_plus_o  = pc_q + PC_W'(PC_INC);

   assign pc_o    = pc_q;
   assign epc_o   = epc_q;
   assign trap_o  = trap_q;
   assign state_o = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
         trap_q  <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (!stall_i) begin
                  if (taken_o && misaligned) begin
                     pc_q    <= TRAP_VEC;
                     epc_q   <= pc_q;
                     trap_q  <= 1'b1;
                     state_q <= TRAP;
                  end else if (taken_o) begin
                     pc_q <= target_i;
                  end else begin
                     pc_q <= pc_plus_o;
                  end
               end
            end
            TRAP: begin
               // pc_q already holds TRAP_VEC; sequential fetch from it
               // resumes on the cycle after the acknowledge.
               if (trap_ack_i) begin
                  trap_q  <= 1'b0;
                  state_q <= RUN;
               end
            end
            default: begin
               state_q <= RUN;
               trap_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BR_PC_STATS_EN
   logic        br_eval;
   logic [15:0] br_cnt_q;
   logic [15:0] taken_cnt_q;

   assign br_eval = active & is_branch_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         if (br_eval && (br_cnt_q != 16'hFFFF))
            br_cnt_q <= br_cnt_q + 16'd1;
         if (br_eval && taken_o && (taken_cnt_q != 16'hFFFF))
            taken_cnt_q <= taken_cnt_q + 16'd1;
      end
   end

   assign br_cnt_o    = br_cnt_q;
   assign taken_cnt_o = taken_cnt_q;
`endif

endmodule : br_pc_unit
